// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the 8-bit RISC-V pipeline.
// Owns the program counter. Issues one 32-bit read at a time over a
// request/response port, and loads the IF/ID register for decode.
// On stall it holds IF/ID. On a redirect it flushes and refetches.
// Ports:
//   clock, reset          clock; synchronous active-low reset
//   imem_req/imem_addr    read request pulse and address (equals pc)
//   imem_rvalid/rdata     read response pulse and instruction word
//   stall                 decode cannot accept; hold IF/ID
//   redirect/redirect_pc  taken branch/jump and its target
//   instruction/if_pc/if_valid  IF/ID register contents
module instruction_fetch #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h00000013
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     instruction,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid
);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     skid;
  logic [PC_W-1:0] target;

  // Redirect targets are word aligned.
  assign target = {redirect_pc[PC_W-1:2], 2'b00};

  // The request is gated in the same cycle by a redirect and by reset.
  // This keeps a stale address from reaching memory.
  assign imem_req  = reset && (state == ISSUE) && !redirect;
  assign imem_addr = pc;

  // FSM, pc, skid and IF/ID register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      skid        <= '0;
      instruction <= NOP;
      if_pc       <= '0;
      if_valid    <= 1'b0;
    end else begin
      // IF/ID gets a bubble when nothing loads, unless a stall (without a
      // redirect) holds it. A load further down overrides this.
      if (redirect || !stall) begin
        instruction <= NOP;
        if_valid    <= 1'b0;
      end

      case (state)
        ISSUE: begin
          if (redirect) pc <= target;
          else          state <= WAIT;
        end

        WAIT: begin
          if (redirect) begin
            // A response in the same cycle is dropped. Otherwise the
            // response is still in flight and must be drained.
            pc    <= target;
            state <= imem_rvalid ? ISSUE : DISCARD;
          end else if (imem_rvalid) begin
            if (stall) begin
              skid  <= imem_rdata;
              state <= HOLD;
            end else begin
              instruction <= imem_rdata;
              if_pc       <= pc;
              if_valid    <= 1'b1;
              pc          <= pc + PC_W'(4);
              state       <= ISSUE;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= ISSUE;
          end else if (!stall) begin
            instruction <= skid;
            if_pc       <= pc;
            if_valid    <= 1'b1;
            pc          <= pc + PC_W'(4);
            state       <= ISSUE;
          end
        end

        DISCARD: begin
          if (redirect)    pc    <= target;
          if (imem_rvalid) state <= ISSUE;
        end

        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized bench for instruction_fetch.
// A flag-based reference model predicts every output on every cycle.
// A memory responder returns responses with random latency.
module tb_instruction_fetch;

  localparam int unsigned PC_W = 8;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clock;
  logic            reset;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     instruction;
  logic [PC_W-1:0] if_pc;
  logic            if_valid;

  instruction_fetch #(.PC_W(PC_W), .RESET_PC(8'h00), .NOP(NOP)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch progress is tracked as independent flags.
  logic [PC_W-1:0] m_pc;
  logic            m_wait;       // our request is outstanding, data wanted
  logic            m_stale;      // outstanding response must be dropped
  logic            m_skid_full;  // fetched word parked behind a stall
  logic [31:0]     m_skid;
  logic [31:0]     m_instr;
  logic [PC_W-1:0] m_ifpc;
  logic            m_valid;

  // Memory responder state.
  logic            mem_pending;
  int              mem_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return !m_wait && !m_stale && !m_skid_full;
  endfunction

  task automatic model_step();
    logic            rv;
    logic            ready;
    logic            load;
    logic [31:0]     d;
    logic [PC_W-1:0] tgt;
    if (!reset) begin
      m_pc = '0; m_wait = 0; m_stale = 0; m_skid_full = 0; m_skid = '0;
      m_instr = NOP; m_ifpc = '0; m_valid = 0;
      return;
    end
    ready = model_ready();
    rv    = imem_rvalid && (m_wait || m_stale);
    tgt   = {redirect_pc[PC_W-1:2], 2'b00};
    load  = 0;
    d     = '0;
    if (redirect) begin
      m_stale     = (m_wait || m_stale) && !rv;
      m_wait      = 0;
      m_skid_full = 0;
      m_pc        = tgt;
      m_instr     = NOP;
      m_valid     = 0;
    end else begin
      if (ready) m_wait = 1;
      else if (m_wait && rv) begin
        m_wait = 0;
        if (stall) begin m_skid = imem_rdata; m_skid_full = 1; end
        else begin load = 1; d = imem_rdata; end
      end else if (m_skid_full && !stall) begin
        load = 1; d = m_skid; m_skid_full = 0;
      end else if (m_stale && rv) m_stale = 0;
      if (load) begin
        m_instr = d; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 8'd4;
      end else if (!stall) begin
        m_instr = NOP; m_valid = 0;
      end
    end
  endtask

  // One clock cycle with the inputs already driven. It checks the request
  // before the edge and the IF/ID register after the edge.
  task automatic cycle();
    logic            exp_req;
    logic            seen_req;
    #1;
    exp_req = reset && model_ready() && !redirect;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    seen_req = imem_req;
    @(posedge clock);
    model_step();
    if (imem_rvalid) mem_pending = 0;
    if (!reset) mem_pending = 0;
    else if (seen_req) begin
      mem_pending = 1;
      mem_cnt     = int'($urandom_range(1, 3));
    end
    #1;
    chk("instruction", instruction, m_instr);
    chk("if_pc", 32'(if_pc), 32'(m_ifpc));
    chk("if_valid", 32'(if_valid), 32'(m_valid));
  endtask

  // Comb check of the request/address for the inputs currently driven.
  task automatic probe(input string tag, input logic exp_req, input logic [PC_W-1:0] exp_addr);
    #1;
    chk({tag, "_req"}, 32'(imem_req), 32'(exp_req));
    if (exp_req) chk({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rdr,
                       input logic [PC_W-1:0] rpc, input logic rv, input logic [31:0] rd);
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    imem_rvalid = rv; imem_rdata = rd;
  endtask

  initial begin
    mem_pending = 0;
    mem_cnt     = 0;
    m_pc = '0; m_wait = 0; m_stale = 0; m_skid_full = 0; m_skid = '0;
    m_instr = NOP; m_ifpc = '0; m_valid = 0;
    drive(0, 0, 0, '0, 0, '0);
    #2;

    // Reset for two cycles.
    cycle();
    cycle();
    chk("rst_instr", instruction, 32'h00000013);
    chk("rst_valid", 32'(if_valid), 32'd0);

    // First fetch after release goes to 0x00, with L=1.
    drive(1, 0, 0, '0, 0, '0);
    probe("first", 1'b1, 8'h00);
    cycle();
    drive(1, 0, 0, '0, 1, 32'h00500093);
    cycle();
    chk("line_instr", instruction, 32'h00500093);
    chk("line_pc", 32'(if_pc), 32'h00);
    chk("line_valid", 32'(if_valid), 32'd1);
    drive(1, 0, 0, '0, 0, '0);
    probe("next", 1'b1, 8'h04);
    cycle();

    // Stall while the response returns: the word is parked, no new request.
    drive(1, 1, 0, '0, 1, 32'h00A00113);
    cycle();
    drive(1, 1, 0, '0, 0, '0);
    probe("hold", 1'b0, 8'h00);
    cycle();
    chk("hold_valid", 32'(if_valid), 32'd0);
    drive(1, 0, 0, '0, 0, '0);
    probe("hold_rel", 1'b0, 8'h00);
    cycle();
    chk("skid_instr", instruction, 32'h00A00113);
    chk("skid_pc", 32'(if_pc), 32'h04);
    chk("skid_valid", 32'(if_valid), 32'd1);
    drive(1, 0, 0, '0, 0, '0);
    probe("after_skid", 1'b1, 8'h08);
    cycle();

    // Redirect while waiting: the stale response is drained and dropped.
    drive(1, 0, 1, 8'h42, 0, '0);
    probe("redir_gate", 1'b0, 8'h00);
    cycle();
    chk("redir_valid", 32'(if_valid), 32'd0);
    drive(1, 0, 0, '0, 1, 32'hDEADBEEF);
    probe("discard", 1'b0, 8'h00);
    cycle();
    chk("stale_instr", instruction, NOP);
    drive(1, 0, 0, '0, 0, '0);
    probe("refetch", 1'b1, 8'h40);
    cycle();

    // Redirect with rvalid and stall in the same cycle: no HOLD is entered.
    drive(1, 1, 1, 8'hFE, 1, 32'h12345678);
    cycle();
    chk("same_instr", instruction, NOP);
    chk("same_valid", 32'(if_valid), 32'd0);
    chk("same_pc", 32'(if_pc), 32'h04);
    drive(1, 0, 0, '0, 0, '0);
    probe("no_hold", 1'b1, 8'hFC);
    cycle();

    // The fetch at 0xFC wraps the pc to 0x00.
    drive(1, 0, 0, '0, 1, 32'h00100073);
    cycle();
    chk("wrap_pc", 32'(if_pc), 32'hFC);
    chk("wrap_valid", 32'(if_valid), 32'd1);
    drive(1, 0, 0, '0, 0, '0);
    probe("wrap", 1'b1, 8'h00);
    cycle();

    // Randomized traffic with a memory that answers after 1..3 cycles.
    for (int i = 0; i < 4000; i++) begin
      logic rst_n;
      logic rv;
      rst_n = ($urandom_range(0, 99) != 0);
      rv    = 0;
      if (mem_pending && rst_n) begin
        mem_cnt--;
        if (mem_cnt <= 0) rv = 1;
      end
      drive(rst_n, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 8),
            PC_W'($urandom), rv, $urandom);
      cycle();
    end

    // The bounded wait for a request after a quiet period.
    drive(0, 0, 0, '0, 0, '0);
    cycle();
    begin
      bit got;
      got = 0;
      drive(1, 0, 0, '0, 0, '0);
      for (int k = 0; k < 4 && !got; k++) begin
        #1;
        if (imem_req) got = 1;
        else cycle();
      end
      chk("req_timeout", 32'(got), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
